// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern detector scheduler.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned DEF_PAT_LEN = 6;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 6'b101011;

  // Index/counter width for n distinct values; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Requester lanes plus match/frame reporting bus of the detector scheduler.
interface seq_det_scheduler_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned FRAME_LEN = 16
);
  import seq_det_pkg::*;

  localparam int unsigned CH_W  = idx_w(NUM_CH);
  localparam int unsigned CNT_W = idx_w(FRAME_LEN + 1);

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] ch_bit;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] grant;
  logic              busy;
  logic              match_pulse;
  logic [CH_W-1:0]   match_ch;
  logic              frame_done;
  logic              frame_abort;
  logic [CH_W-1:0]   frame_ch;
  logic [CNT_W-1:0]  frame_match_cnt;

  modport master (
    output req, ch_bit, ch_valid,
    input  grant, busy, match_pulse, match_ch,
    input  frame_done, frame_abort, frame_ch, frame_match_cnt
  );

  modport slave (
    input  req, ch_bit, ch_valid,
    output grant, busy, match_pulse, match_ch,
    output frame_done, frame_abort, frame_ch, frame_match_cnt
  );

endinterface

// File: rtl/pattern_matcher.sv
// Serial pattern detector: shift history, saturating fill count, sync clear,
// combinational hit for the bit being accepted and its registered match pulse.
module pattern_matcher
  import seq_det_pkg::*;
#(
  parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit_c,
  output logic match
);

  localparam int unsigned FILL_W = idx_w(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] hist_next_c;
  logic               full_next_c;

  assign hist_next_c = {hist[PAT_LEN-2:0], bit_in};
  assign full_next_c = (fill >= FILL_W'(PAT_LEN - 1));
  assign hit_c       = bit_valid && !clear && full_next_c && (hist_next_c == PATTERN);

  // History and fill only ever advance on accepted bits; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else if (clear) begin
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      match <= hit_c;
      if (bit_valid) begin
        hist <= hist_next_c;
        if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin frame scheduler sharing one pattern matcher among NUM_CH
// serial requesters, with per-frame hit counting.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned        NUM_CH    = 4,
  parameter int unsigned        FRAME_LEN = 16,
  parameter int unsigned        PAT_LEN   = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN   = DEF_PATTERN
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_det_scheduler_if.slave bus
);

  localparam int unsigned CH_W  = idx_w(NUM_CH);
  localparam int unsigned CNT_W = idx_w(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CH_W-1:0]  MAX_CH   = CH_W'(NUM_CH - 1);

  state_t           state;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  gidx;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] match_cnt;

  logic             pick_ok_c;
  logic [CH_W-1:0]  pick_c;
  logic [CH_W-1:0]  cand_c;
  logic             accept_c;
  logic             abort_c;
  logic             last_c;
  logic             hit_c;
  logic [CNT_W-1:0] cnt_inc_c;

  // First requester at or after rr_ptr, wrapping upward.
  always_comb begin
    pick_ok_c = 1'b0;
    pick_c    = '0;
    cand_c    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand_c = CH_W'((32'(rr_ptr) + i) % NUM_CH);
      if (!pick_ok_c && bus.req[cand_c]) begin
        pick_ok_c = 1'b1;
        pick_c    = cand_c;
      end
    end
  end

  // A dropped request ends the frame and discards any bit offered alongside it.
  assign accept_c  = (state == STREAM) && bus.req[gidx] && bus.ch_valid[gidx];
  assign abort_c   = (state == STREAM) && !bus.req[gidx];
  assign last_c    = accept_c && (bit_cnt == LAST_IDX);
  assign cnt_inc_c = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);

  pattern_matcher #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (state == IDLE),
    .bit_valid (accept_c),
    .bit_in    (bus.ch_bit[gidx]),
    .hit_c     (hit_c),
    .match     (bus.match_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      rr_ptr              <= '0;
      gidx                <= '0;
      bit_cnt             <= '0;
      match_cnt           <= '0;
      bus.grant           <= '0;
      bus.busy            <= 1'b0;
      bus.match_ch        <= '0;
      bus.frame_done      <= 1'b0;
      bus.frame_abort     <= 1'b0;
      bus.frame_ch        <= '0;
      bus.frame_match_cnt <= '0;
    end else begin
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt   <= '0;
          match_cnt <= '0;
          if (pick_ok_c) begin
            gidx      <= pick_c;
            bus.grant <= NUM_CH'(1) << pick_c;
            bus.busy  <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (accept_c) begin
            bit_cnt      <= bit_cnt + CNT_W'(1);
            bus.match_ch <= gidx;
          end
          if (hit_c) match_cnt <= cnt_inc_c;
          // The final bit's hit is folded into the reported count here.
          if (abort_c || last_c) begin
            state               <= DONE;
            bus.grant           <= '0;
            bus.frame_done      <= 1'b1;
            bus.frame_abort     <= abort_c;
            bus.frame_ch        <= gidx;
            bus.frame_match_cnt <= hit_c ? cnt_inc_c : match_cnt;
          end
        end
        DONE: begin
          rr_ptr   <= (gidx == MAX_CH) ? '0 : gidx + CH_W'(1);
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Scoreboard bench for seq_det_scheduler: directed frames push expectations,
// a negedge monitor pops and compares them as the DUT reports events.
module tb_seq_det_scheduler;
  import seq_det_pkg::*;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned FRAME_LEN = 16;

  typedef struct {
    int cyc;
    int ch;
  } match_exp_t;

  typedef struct {
    int ch;
    int abort;
    int cnt;
    int len;
  } frame_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  match_exp_t   match_q[$];
  frame_exp_t   frame_q[$];
  logic [3:0]   grant_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_scheduler_if #(.NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN)) bus ();

  seq_det_scheduler #(
    .NUM_CH    (NUM_CH),
    .FRAME_LEN (FRAME_LEN),
    .PAT_LEN   (6),
    .PATTERN   (6'b101011)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every reported grant, match and frame against the queues.
  initial begin : monitor
    logic [3:0] prev_grant;
    int         grant_cyc;
    logic [3:0] g;
    match_exp_t m;
    frame_exp_t f;
    prev_grant = '0;
    grant_cyc  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_grant = '0;
      end else begin
        if (bus.grant != prev_grant && bus.grant != '0) begin
          grant_cyc = cyc;
          if (grant_q.size() == 0) check("unexpected_grant", int'(bus.grant), 0);
          else begin
            g = grant_q.pop_front();
            check("grant", int'(bus.grant), int'(g));
          end
        end
        prev_grant = bus.grant;
        if (bus.match_pulse) begin
          if (match_q.size() == 0) check("unexpected_match_ch", int'(bus.match_ch), -1);
          else begin
            m = match_q.pop_front();
            check("match_cycle", cyc, m.cyc);
            check("match_ch", int'(bus.match_ch), m.ch);
          end
        end
        if (bus.frame_done) begin
          if (frame_q.size() == 0) check("unexpected_frame_ch", int'(bus.frame_ch), -1);
          else begin
            f = frame_q.pop_front();
            check("frame_ch", int'(bus.frame_ch), f.ch);
            check("frame_abort", int'(bus.frame_abort), f.abort);
            check("frame_match_cnt", int'(bus.frame_match_cnt), f.cnt);
            check("stream_cycles", cyc - grant_cyc, f.len);
            check("done_grant", int'(bus.grant), 0);
            check("done_busy", int'(bus.busy), 1);
          end
        end
      end
    end
  end

  task automatic wait_grant(input int ch, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus.grant[ch]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: channel %0d never granted, required grant within 60 cycles", ch);
    end
  endtask

  // Streams nacc bits (MSB first) on ch once granted; hits marks completing bits.
  task automatic run_frame(input int ch, input logic [15:0] bits, input logic [15:0] hits,
                           input bit gap, input int nacc, input bit abort, input int exp_cnt,
                           input logic [3:0] add_req, input logic [3:0] rel_req);
    frame_exp_t f;
    match_exp_t m;
    bit         ok;
    f.ch    = ch;
    f.abort = int'(abort);
    f.cnt   = exp_cnt;
    f.len   = abort ? nacc + 1 : (gap ? 2 * nacc : nacc);
    frame_q.push_back(f);
    wait_grant(ch, ok);
    if (!ok) return;
    bus.req = bus.req | add_req;
    for (int k = 0; k < nacc; k++) begin
      if (gap) begin
        bus.ch_valid[ch] = 1'b0;
        bus.ch_bit[ch]   = 1'b1;
        @(posedge clk);
        #1;
      end
      bus.ch_valid[ch] = 1'b1;
      bus.ch_bit[ch]   = bits[15-k];
      if (hits[15-k]) begin
        m.cyc = cyc + 1;
        m.ch  = ch;
        match_q.push_back(m);
      end
      @(posedge clk);
      #1;
    end
    if (abort) begin
      bus.req[ch]      = 1'b0;
      bus.ch_valid[ch] = 1'b1;
      bus.ch_bit[ch]   = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.ch_valid[ch] = 1'b0;
    bus.ch_bit[ch]   = 1'b0;
    bus.req          = bus.req & ~rel_req;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, int'(bus.grant), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_match_pulse"}, int'(bus.match_pulse), 0);
    check({tag, "_match_ch"}, int'(bus.match_ch), 0);
    check({tag, "_frame_done"}, int'(bus.frame_done), 0);
    check({tag, "_frame_abort"}, int'(bus.frame_abort), 0);
    check({tag, "_frame_ch"}, int'(bus.frame_ch), 0);
    check({tag, "_frame_match_cnt"}, int'(bus.frame_match_cnt), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    bus.req      = '0;
    bus.ch_bit   = '0;
    bus.ch_valid = '0;
    #12;
    check_all_zero("reset");
    #5 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_grant", int'(bus.grant), 0);
    check("idle_busy", int'(bus.busy), 0);

    // Round-robin from rr_ptr=0 with isolation across ch0 -> ch1 frames.
    grant_q.push_back(4'b0001);
    grant_q.push_back(4'b0010);
    grant_q.push_back(4'b1000);
    grant_q.push_back(4'b0001);
    bus.req = 4'b1011;
    run_frame(0, 16'b0000000000010101, 16'b0000000000000000, 0, 16, 0, 0, 4'b0000, 4'b0000);
    run_frame(1, 16'b1000000000000000, 16'b0000000000000000, 0, 16, 0, 0, 4'b0000, 4'b0000);
    run_frame(3, 16'b0000101011000000, 16'b0000000001000000, 0, 16, 0, 1, 4'b0000, 4'b0000);
    run_frame(0, 16'b1010110101100000, 16'b0000010000100000, 0, 16, 0, 2, 4'b0000, 4'b1011);

    // Single hit on ch2.
    grant_q.push_back(4'b0100);
    bus.req = 4'b0100;
    run_frame(2, 16'b0000101011000000, 16'b0000000001000000, 0, 16, 0, 1, 4'b0000, 4'b0100);

    // Overlapping hits on ch0.
    grant_q.push_back(4'b0001);
    bus.req = 4'b0001;
    run_frame(0, 16'b1010110101100000, 16'b0000010000100000, 0, 16, 0, 2, 4'b0000, 4'b0001);

    // Valid gaps on ch3: 32 stream cycles, same result as gap-free.
    grant_q.push_back(4'b1000);
    bus.req = 4'b1000;
    run_frame(3, 16'b0000101011000000, 16'b0000000001000000, 1, 16, 0, 1, 4'b0000, 4'b1000);

    // Abort on ch1 after 10101; discarded trailing 1 must not complete a hit.
    grant_q.push_back(4'b0010);
    grant_q.push_back(4'b1000);
    bus.req = 4'b0010;
    run_frame(1, 16'b1010100000000000, 16'b0000000000000000, 0, 5, 1, 0, 4'b1001, 4'b0000);

    // ch3 granted next; reset lands during its bit 8.
    wait_grant(3, ok);
    if (ok) begin
      for (int k = 0; k < 7; k++) begin
        bus.ch_valid[3] = 1'b1;
        bus.ch_bit[3]   = 1'b1;
        @(posedge clk);
        #1;
      end
      bus.ch_valid[3] = 1'b1;
      bus.ch_bit[3]   = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
    end
    bus.ch_valid = '0;
    bus.ch_bit   = '0;
    bus.req      = 4'b1111;
    grant_q.push_back(4'b0001);
    @(posedge clk);
    #2 reset_n = 1'b1;
    run_frame(0, 16'b0000101011000000, 16'b0000000001000000, 0, 16, 0, 1, 4'b0000, 4'b1111);

    repeat (6) @(posedge clk);
    #1;
    check("pending_matches", match_q.size(), 0);
    check("pending_frames", frame_q.size(), 0);
    check("pending_grants", grant_q.size(), 0);
    check("final_busy", int'(bus.busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
# seq_det_scheduler

Round-robin scheduler that shares a single serial pattern detector among NUM_CH bit-stream requesters. It grants one channel at a time for a frame of FRAME_LEN accepted bits and clears the detector at every frame boundary. It reports each pattern hit in real time and a per-frame hit count. It sits between the serial ingress lanes and downstream match-event logic.

## Interface
- NUM_CH, 4: number of requesting channels (≥2).
- FRAME_LEN, 16: accepted bits per granted frame (≥PAT_LEN).
- PAT_LEN, 6: pattern length in bits.
- PATTERN, 6'b101011: target pattern; MSB is the first bit received.
- clk in 1: single clock; all logic on rising edge.
- reset_n in 1: asynchronous, active-low reset.
- req in NUM_CH: per-channel frame request; held high for the whole frame.
- ch_bit in NUM_CH: per-channel serial data bit.
- ch_valid in NUM_CH: per-channel bit qualifier.
- grant out NUM_CH: one-hot grant; high for the entire STREAM state.
- busy out 1: high in STREAM and DONE.
- match_pulse out 1: one-cycle pulse per detected pattern.
- match_ch out clog2(NUM_CH): granted channel index; valid with match_pulse.
- frame_done out 1: one-cycle pulse at frame end.
- frame_abort out 1: qualifies frame_done; frame was cut short.
- frame_ch out clog2(NUM_CH): channel index of the completed frame.
- frame_match_cnt out clog2(FRAME_LEN+1): hits in the frame; valid with frame_done.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - If req≠0, pick the first set req at or after rr_ptr, searching upward with wrap.
  - Register grant and go to STREAM.
  - Assert detector clear; zero bit_cnt and match_cnt.
- STREAM:
  - A bit is accepted when ch_valid[g] is high; ch_bit[g] shifts into the detector and bit_cnt increments.
  - ch_valid low stalls the frame with no timeout.
- Exit from STREAM:
  - Accepting bit number FRAME_LEN: go to DONE with frame_abort=0.
  - req[g] low in any STREAM cycle: go to DONE with frame_abort=1. A bit valid in that same cycle is discarded.
- DONE (one cycle):
  - frame_done=1; grant=0.
  - rr_ptr ← (g+1) mod NUM_CH.
  - Go to IDLE.
- Detector matching:
  - Keeps a PAT_LEN-bit history plus a fill count saturating at PAT_LEN.
  - A match is declared when fill count = PAT_LEN and the history, including the bit just accepted, equals PATTERN.
  - Overlapping matches count.
  - History never spans frames, because it is cleared in IDLE.
- match_cnt saturates at its maximum; by construction it cannot overflow.

## Timing
- Reset values: grant=0, busy=0, match_pulse=0, match_ch=0, frame_done=0, frame_abort=0, frame_ch=0, frame_match_cnt=0, rr_ptr=0, state=IDLE.
- Grant latency: req seen in IDLE cycle t → grant high from cycle t+1. The first bit can be accepted in cycle t+1.
- Match latency: completing bit accepted in cycle t → match_pulse high in cycle t+1, and match_cnt is updated at the same edge.
- The last bit's match, if any, is included in frame_match_cnt at DONE.
- Minimum frame length: FRAME_LEN+2 cycles (IDLE, FRAME_LEN STREAM cycles, DONE). No back-to-back grant without an intervening IDLE.
- frame_match_cnt and frame_ch hold their value until the next frame_done.
- Reset mid-frame: everything returns to reset values immediately. No frame_done is issued for the interrupted frame.

## Structure
- Shared package seq_det_pkg holds:
  - the state enum (IDLE, STREAM, DONE);
  - default PATTERN/PAT_LEN constants;
  - a clog2-based width helper.
- Sub-module pattern_matcher holds the shift history, fill count, sync clear and registered match. It is parameterised by PAT_LEN/PATTERN and reusable by other detector users.
- The scheduler contains the arbiter, FSM, counters and output registers.

## Test plan
All scenarios use NUM_CH=4, FRAME_LEN=16, PATTERN=101011.
- Single hit:
  - Stimulus: req=0100; ch2 streams 0000101011000000 with continuous valid.
  - Required: match_pulse one cycle after bit 10; frame_done with frame_ch=2, frame_match_cnt=1, abort=0.
- Overlap:
  - Stimulus: ch0 streams 1010110101100000.
  - Required: pulses after bits 6 and 11; frame_match_cnt=2.
- Round-robin and cross-frame isolation:
  - Stimulus: req=1011 held. Ch0's frame ends …10101; ch1's frame starts with 1 and has no further pattern.
  - Required: grant order 0001, 0010, 1000, 0001; ch1 frame_match_cnt=0.
- Valid gaps:
  - Stimulus: ch3 drives ch_valid alternating 1/0.
  - Required: frame spans 32 STREAM cycles; results identical to the gap-free case.
- Abort:
  - Stimulus: ch1 drops req after 5 accepted bits 10101.
  - Required: frame_done with abort=1, frame_match_cnt=0; next grant goes to the next requester after ch1.
- Reset mid-STREAM:
  - Stimulus: assert reset_n low during bit 8.
  - Required: all outputs 0 asynchronously; after release with req=1111, first grant=0001.
